// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_pkg
//  Description : Shared types and helpers for the digit-by-digit integer
//                square-root unit (and sibling root / divider units).
//                - state_t           : two-state sequencer encoding
//                - init_mask_pos()   : bit position of the initial root mask
//  Revision    : 1.0  initial release
// ============================================================================
package isqrt_pkg;

    // Sequencer states: waiting for a start, or iterating root steps.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    // The first trial bit of the root sits at the top even bit position of
    // the radicand, i.e. mask = 1 << (width - 2).
    function automatic int unsigned init_mask_pos(input int unsigned width);
        return width - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq_if
//  Description : Start/busy/done handshake and data bus of the sequential
//                integer square-root unit.
//                x_bi    radicand (WIDTH)           requester -> unit
//                start_i start request              requester -> unit
//                busy_o  computation in progress    unit -> requester
//                done_o  one-cycle result pulse     unit -> requester
//                y_bo    root (WIDTH/2)             unit -> requester
//                rem_bo  remainder (WIDTH/2+1)      unit -> requester
//  Revision    : 1.0  initial release
// ============================================================================
interface isqrt_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   x_bi;
    logic               start_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH/2-1:0] y_bo;
    logic [WIDTH/2:0]   rem_bo;

    // Requester side.
    modport master (
        output x_bi,
        output start_i,
        input  busy_o,
        input  done_o,
        input  y_bo,
        input  rem_bo
    );

    // Square-root unit side.
    modport slave (
        input  x_bi,
        input  start_i,
        output busy_o,
        output done_o,
        output y_bo,
        output rem_bo
    );
endinterface
`default_nettype wire

// File: rtl/isqrt_step.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_step
//  Description : One combinational digit-by-digit square-root step
//                (consumes two radicand bits, produces one root bit).
//                i_x/o_x  partial remainder     (WIDTH)
//                i_y/o_y  partial root accum.   (WIDTH)
//                i_m/o_m  current trial mask    (WIDTH)
//  Revision    : 1.0  initial release
// ============================================================================
module isqrt_step #(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH-1:0] i_x,
    input  wire logic [WIDTH-1:0] i_y,
    input  wire logic [WIDTH-1:0] i_m,
    output logic      [WIDTH-1:0] o_x,
    output logic      [WIDTH-1:0] o_y,
    output logic      [WIDTH-1:0] o_m
);
    logic [WIDTH-1:0] w_b;
    logic             w_ge;

    // Trial subtrahend: current root (kept pre-shifted) with the new bit set.
    assign w_b  = i_y | i_m;
    assign w_ge = (i_x >= w_b);

    assign o_x  = w_ge ? (i_x - w_b) : i_x;
    assign o_y  = w_ge ? ((i_y >> 1) | i_m) : (i_y >> 1);
    assign o_m  = i_m >> 2;
endmodule
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq
//  Description : Sequential integer square root: y = floor(sqrt(x)),
//                rem = x - y*y. UNROLL chained root steps per clock,
//                WIDTH/2/UNROLL working cycles per operation.
//                clk_i   clock, rising edge
//                rst_ni  synchronous active-low reset
//                bus     isqrt_seq_if slave: x_bi, start_i, busy_o, done_o,
//                        y_bo, rem_bo
//  Revision    : 1.0  initial release
// ============================================================================
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int UNROLL = 1
) (
    input  wire logic  clk_i,
    input  wire logic  rst_ni,
    isqrt_seq_if.slave bus
);
    localparam int c_HALF   = WIDTH / 2;
    localparam int c_CYCLES = (UNROLL > 0) ? (c_HALF / UNROLL) : 1;
    localparam int c_CNT_W  = (c_CYCLES > 1) ? $clog2(c_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_CYCLES - 1);
    localparam logic [WIDTH-1:0]   c_M0   =
        {{(WIDTH-1){1'b0}}, 1'b1} << init_mask_pos(WIDTH);

    if ((WIDTH % 2) != 0 || WIDTH < 4 || UNROLL < 1 || (c_HALF % UNROLL) != 0)
    begin : g_param_check
        $error("isqrt_seq: WIDTH must be even and >= 4, UNROLL must divide WIDTH/2");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_finish;

    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_m;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;
    logic [c_HALF-1:0]  r_y_res;
    logic [c_HALF:0]    r_rem_res;

    logic [WIDTH-1:0]   w_x_fin;
    logic [WIDTH-1:0]   w_y_fin;
    logic [WIDTH-1:0]   w_m_fin;

    // Step chain: each stage owns its wires so the chain has no
    // self-referencing vector.
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
        logic [WIDTH-1:0] w_x_in, w_y_in, w_m_in;
        logic [WIDTH-1:0] w_x_out, w_y_out, w_m_out;

        if (gi == 0) begin : g_first
            assign w_x_in = r_x;
            assign w_y_in = r_y;
            assign w_m_in = r_m;
        end else begin : g_next
            assign w_x_in = g_step[gi-1].w_x_out;
            assign w_y_in = g_step[gi-1].w_y_out;
            assign w_m_in = g_step[gi-1].w_m_out;
        end

        isqrt_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .i_x (w_x_in),
            .i_y (w_y_in),
            .i_m (w_m_in),
            .o_x (w_x_out),
            .o_y (w_y_out),
            .o_m (w_m_out)
        );
    end

    assign w_x_fin = g_step[UNROLL-1].w_x_out;
    assign w_y_fin = g_step[UNROLL-1].w_y_out;
    assign w_m_fin = g_step[UNROLL-1].w_m_out;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                // Includes the done cycle, giving zero-gap back-to-back.
                if (bus.start_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = WORK;
                end
            end
            WORK: begin
                if (r_cnt == c_LAST) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_x       <= '0;
            r_y       <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_y_res   <= '0;
            r_rem_res <= '0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_x   <= bus.x_bi;
                r_y   <= '0;
                r_m   <= c_M0;
                r_cnt <= '0;
            end else if (r_state == WORK) begin
                r_x   <= w_x_fin;
                r_y   <= w_y_fin;
                r_m   <= w_m_fin;
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            // After the last step the root fits WIDTH/2 bits and the
            // remainder (<= 2*y) fits WIDTH/2+1 bits.
            if (w_finish) begin
                r_y_res   <= w_y_fin[c_HALF-1:0];
                r_rem_res <= w_x_fin[c_HALF:0];
            end
        end
    end

    assign bus.busy_o = (r_state == WORK);
    assign bus.done_o = r_done;
    assign bus.y_bo   = r_y_res;
    assign bus.rem_bo = r_rem_res;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isqrt_seq
//  Description : Self-checking bench for isqrt_seq. Six configurations run
//                in parallel (W=8 U=1/2/4, W=16 U=1/2, W=32 U=4); each has a
//                randomised driver pushing expected results from a plain
//                arithmetic square-root model into a queue, and a monitor
//                that compares on every done_o pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_isqrt_seq;
    localparam int NCFG = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    longint unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [NCFG-1:0] fin = '0;

    typedef struct {
        longint unsigned y;
        longint unsigned rem;
        longint unsigned t;
    } exp_t;

    // floor(sqrt(x)) from real arithmetic, corrected to the exact integer.
    function automatic longint unsigned ref_root(input longint unsigned x);
        longint unsigned r;
        r = longint'($rtoi($sqrt(real'(x))));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic void chk(input string name, input longint unsigned act,
                                input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = (g < 3) ? 8 : ((g < 5) ? 16 : 32);
        localparam int U = (g == 0 || g == 3) ? 1 : ((g == 1 || g == 4) ? 2 : 4);
        localparam int C = W / 2 / U;

        logic rst_n;
        isqrt_seq_if #(.WIDTH(W)) bus ();

        isqrt_seq #(
            .WIDTH  (W),
            .UNROLL (U)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .bus    (bus)
        );

        exp_t            q[$];
        longint unsigned last_y   = 0;
        longint unsigned last_rem = 0;

        // Monitor: sampled on the falling edge.
        always @(negedge clk) begin : mon
            exp_t e;
            if (rst_n) begin
                if (bus.done_o) begin
                    if (q.size() == 0) begin
                        chk($sformatf("cfg%0d_spurious_done", g), 64'(bus.done_o), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("cfg%0d_y", g), 64'(bus.y_bo), e.y);
                        chk($sformatf("cfg%0d_rem", g), 64'(bus.rem_bo), e.rem);
                        // Accepted at edge t, busy for C cycles, done
                        // registered by edge t+C (the cycle after busy).
                        chk($sformatf("cfg%0d_latency", g), cyc - e.t, 64'(C));
                        chk($sformatf("cfg%0d_busy_at_done", g), 64'(bus.busy_o), 64'd0);
                        last_y   = e.y;
                        last_rem = e.rem;
                    end
                end else begin
                    chk($sformatf("cfg%0d_y_hold", g), 64'(bus.y_bo), last_y);
                    chk($sformatf("cfg%0d_rem_hold", g), 64'(bus.rem_bo), last_rem);
                    if (q.size() != 0)
                        chk($sformatf("cfg%0d_busy", g), 64'(bus.busy_o), 64'd1);
                end
            end
        end

        // Driver: decisions made 1 time unit after each rising edge.
        initial begin : drv
            logic [W-1:0]    ops[$];
            exp_t            e;
            longint unsigned r;
            longint unsigned xv;
            longint unsigned sq;
            int              k;
            int              gap;
            int              guard;
            int              rst_at;
            bit              did_rst;
            int unsigned     roots[10];

            roots   = '{1, 2, 3, 15, 16, 255, 256, 4095, 46340, 65535};
            did_rst = 1'b0;
            rst_n       = 1'b0;
            bus.start_i = 1'b0;
            bus.x_bi    = '0;

            if (W == 8) begin
                for (int v = 0; v < 256; v++) ops.push_back(W'(v));
            end else if (W == 16) begin
                ops.push_back(W'(0));
                ops.push_back(W'(65535));
                ops.push_back(W'(144));
                ops.push_back(W'(145));
                ops.push_back(W'(1000));
                for (int i = 0; i < 300; i++) ops.push_back(W'($urandom));
            end else begin
                ops.push_back(W'(0));
                ops.push_back(W'(1));
                ops.push_back(W'(64'hFFFF_FFFF));
                for (int i = 0; i < 10; i++) begin
                    sq = 64'(roots[i]) * 64'(roots[i]);
                    ops.push_back(W'(sq));
                    ops.push_back(W'(sq - 1));
                    ops.push_back(W'(sq + 1));
                end
                for (int i = 0; i < 10000; i++) ops.push_back(W'($urandom));
            end

            // Reset lands in the third working cycle where C >= 4.
            rst_at = (C >= 4) ? 2 : -1;

            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            chk($sformatf("cfg%0d_rst_busy", g), 64'(bus.busy_o), 64'd0);
            chk($sformatf("cfg%0d_rst_done", g), 64'(bus.done_o), 64'd0);
            chk($sformatf("cfg%0d_rst_y", g), 64'(bus.y_bo), 64'd0);
            chk($sformatf("cfg%0d_rst_rem", g), 64'(bus.rem_bo), 64'd0);

            k = 0;
            while (k < ops.size()) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    bus.start_i = 1'b0;
                    @(posedge clk);
                    #1;
                end
                // While busy, keep start high with junk operands: ignored.
                guard = 0;
                while (bus.busy_o && guard < 64) begin
                    bus.start_i = 1'b1;
                    bus.x_bi    = W'($urandom);
                    @(posedge clk);
                    #1;
                    guard++;
                end
                if (guard >= 64) begin
                    chk($sformatf("cfg%0d_stuck_busy", g), 64'(bus.busy_o), 64'd0);
                    break;
                end
                bus.start_i = 1'b1;
                bus.x_bi    = ops[k];
                @(posedge clk);
                #1;
                xv    = 64'(ops[k]);
                r     = ref_root(xv);
                e.y   = r;
                e.rem = xv - r * r;
                e.t   = cyc;
                q.push_back(e);
                bus.start_i = ($urandom_range(0, 1) == 1);
                bus.x_bi    = W'($urandom);

                if (k == rst_at && !did_rst) begin
                    did_rst = 1'b1;
                    repeat (2) begin
                        @(posedge clk);
                        #1;
                    end
                    rst_n = 1'b0;
                    @(posedge clk);
                    #1;
                    rst_n       = 1'b1;
                    bus.start_i = 1'b0;
                    q.delete();
                    last_y   = 0;
                    last_rem = 0;
                    chk($sformatf("cfg%0d_abort_busy", g), 64'(bus.busy_o), 64'd0);
                    chk($sformatf("cfg%0d_abort_done", g), 64'(bus.done_o), 64'd0);
                    chk($sformatf("cfg%0d_abort_y", g), 64'(bus.y_bo), 64'd0);
                    chk($sformatf("cfg%0d_abort_rem", g), 64'(bus.rem_bo), 64'd0);
                    // Same operand is re-issued as a fresh start.
                end else begin
                    k++;
                end
            end

            bus.start_i = 1'b0;
            guard = 0;
            while (q.size() != 0 && guard < 200) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (q.size() != 0)
                chk($sformatf("cfg%0d_drain", g), 64'(q.size()), 64'd0);
            fin[g] = 1'b1;
        end
    end

    initial begin : summary
        int guard;
        guard = 0;
        while (fin != {NCFG{1'b1}} && guard < 95000) begin
            @(posedge clk);
            guard++;
        end
        if (fin != {NCFG{1'b1}}) begin
            errors++;
            $display("FAIL timeout finished=%b required=%b", fin, {NCFG{1'b1}});
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
